// File: rtl/light_phase_controller.sv
// light_phase_controller: sequences the north-south and east-west signal
// heads and the pedestrian walk lamp from the 2-bit traffic mode. Day cycle,
// pedestrian walk insertion, emergency all-red pre-emption and night flashing
// are all handled by one timer-driven state machine. Outputs are decoded from
// registered state only.
module light_phase_controller #(
  parameter int DAY_GREEN   = 8,
  parameter int YELLOW_TIME = 3,
  parameter int RED_TIME    = 2,
  parameter int WALK_TIME   = 5,
  parameter int FLASH_HALF  = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] trafficMode,
  output logic [1:0] nsLight,
  output logic [1:0] ewLight,
  output logic       walk,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    NS_GRN = 4'd0,
    NS_YEL = 4'd1,
    CLR    = 4'd2,
    EW_GRN = 4'd3,
    EW_YEL = 4'd4,
    PED    = 4'd5,
    EMG    = 4'd6,
    NIGHT  = 4'd7
  } state_t;

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;
  localparam logic [1:0] LAMP_DARK   = 2'b11;

  // The timer holds "cycles left minus one", so each load is duration-1.
  localparam logic [7:0] GRN_LOAD   = 8'(DAY_GREEN - 1);
  localparam logic [7:0] YEL_LOAD   = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] RED_LOAD   = 8'(RED_TIME - 1);
  localparam logic [7:0] WALK_LOAD  = 8'(WALK_TIME - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_HALF - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       next_dir_q, next_dir_d;
  logic       ped_pending_q, ped_pending_d;
  logic       flash_q, flash_d;

  logic       emergency;
  logic       expired;
  logic       ped_request;

  assign emergency   = (trafficMode == MODE_EMG);
  assign expired     = (timer_q == 8'd0);
  // A request arriving in the very cycle CLR expires is still serviced.
  assign ped_request = ped_pending_q | (trafficMode == MODE_PED);

  // Next-state logic: timer countdown, phase sequencing and pre-emption.
  always_comb begin
    state_d       = state_q;
    timer_d       = expired ? timer_q : timer_q - 8'd1;
    next_dir_d    = next_dir_q;
    ped_pending_d = ped_request;
    flash_d       = flash_q;

    case (state_q)
      NS_GRN: begin
        if (emergency || expired) begin
          state_d = NS_YEL;
          timer_d = YEL_LOAD;
        end
      end
      NS_YEL: begin
        if (expired) begin
          state_d    = CLR;
          timer_d    = RED_LOAD;
          next_dir_d = 1'b1;
        end
      end
      EW_GRN: begin
        if (emergency || expired) begin
          state_d = EW_YEL;
          timer_d = YEL_LOAD;
        end
      end
      EW_YEL: begin
        if (expired) begin
          state_d    = CLR;
          timer_d    = RED_LOAD;
          next_dir_d = 1'b0;
        end
      end
      CLR: begin
        if (expired) begin
          if (emergency) begin
            state_d = EMG;
          end else if (ped_request) begin
            state_d       = PED;
            timer_d       = WALK_LOAD;
            ped_pending_d = 1'b0;
          end else if (trafficMode == MODE_NIGHT) begin
            state_d = NIGHT;
            timer_d = FLASH_LOAD;
            flash_d = 1'b0;
          end else if (next_dir_q) begin
            state_d = EW_GRN;
            timer_d = GRN_LOAD;
          end else begin
            state_d = NS_GRN;
            timer_d = GRN_LOAD;
          end
        end
      end
      PED: begin
        if (emergency) begin
          state_d = EMG;
        end else if (expired) begin
          state_d = next_dir_q ? EW_GRN : NS_GRN;
          timer_d = GRN_LOAD;
        end
      end
      EMG: begin
        if (!emergency) begin
          state_d    = CLR;
          timer_d    = RED_LOAD;
          next_dir_d = 1'b0;
        end
      end
      NIGHT: begin
        if (emergency) begin
          state_d = EMG;
        end else if (trafficMode != MODE_NIGHT) begin
          state_d    = CLR;
          timer_d    = RED_LOAD;
          next_dir_d = 1'b0;
        end else if (expired) begin
          flash_d = ~flash_q;
          timer_d = FLASH_LOAD;
        end
      end
      default: begin
        state_d = CLR;
        timer_d = RED_LOAD;
      end
    endcase
  end

  // State registers with synchronous active-low reset into all-red clearance.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q       <= CLR;
      timer_q       <= RED_LOAD;
      next_dir_q    <= 1'b0;
      ped_pending_q <= 1'b0;
      flash_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      flash_q       <= flash_d;
    end
  end

  // Lamp decode from registered state; a green is only ever paired with red.
  always_comb begin
    nsLight = LAMP_RED;
    ewLight = LAMP_RED;
    walk    = 1'b0;
    case (state_q)
      NS_GRN: nsLight = LAMP_GREEN;
      NS_YEL: nsLight = LAMP_YELLOW;
      EW_GRN: ewLight = LAMP_GREEN;
      EW_YEL: ewLight = LAMP_YELLOW;
      PED:    walk    = 1'b1;
      NIGHT: begin
        nsLight = flash_q ? LAMP_DARK : LAMP_YELLOW;
        ewLight = flash_q ? LAMP_DARK : LAMP_RED;
      end
      default: begin
        nsLight = LAMP_RED;
        ewLight = LAMP_RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_light_phase_controller.sv
// Bench for light_phase_controller: a behavioural model that tracks the phase
// and how long it has lasted, directed literal checks of the key scenarios,
// then a long run of randomized mode sequences with occasional resets.
module tb_light_phase_controller;

  localparam int DAY_GREEN   = 8;
  localparam int YELLOW_TIME = 3;
  localparam int RED_TIME    = 2;
  localparam int WALK_TIME   = 5;
  localparam int FLASH_HALF  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] traffic_mode = 2'b00;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic [3:0] phase;

  int checks = 0;
  int errors = 0;

  bit m_valid = 1'b0;
  int m_state = 2;
  int m_elapsed = 0;
  bit m_next = 1'b0;
  bit m_ped = 1'b0;

  light_phase_controller #(
    .DAY_GREEN  (DAY_GREEN),
    .YELLOW_TIME(YELLOW_TIME),
    .RED_TIME   (RED_TIME),
    .WALK_TIME  (WALK_TIME),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clk        (clk),
    .rstN       (rst_n),
    .trafficMode(traffic_mode),
    .nsLight    (ns_light),
    .ewLight    (ew_light),
    .walk       (walk),
    .phase      (phase)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // How many cycles a timed phase lasts; 0 for untimed phases.
  function automatic int dwell(input int s);
    case (s)
      0, 3:    return DAY_GREEN;
      1, 4:    return YELLOW_TIME;
      2:       return RED_TIME;
      5:       return WALK_TIME;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances the phase from elapsed-time counts each edge.
  always @(posedge clk) begin : model_update
    int  nxt;
    bit  done;
    int  mode;
    mode = int'(traffic_mode);
    if (!rst_n) begin
      m_state   = 2;
      m_elapsed = 0;
      m_next    = 1'b0;
      m_ped     = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      nxt = m_state;
      if (mode == 2) m_ped = 1'b1;
      done = (dwell(m_state) > 0) && (m_elapsed >= dwell(m_state) - 1);
      case (m_state)
        0: if (mode == 3 || done) nxt = 1;
        1: if (done) begin nxt = 2; m_next = 1'b1; end
        3: if (mode == 3 || done) nxt = 4;
        4: if (done) begin nxt = 2; m_next = 1'b0; end
        2: if (done) begin
             if (mode == 3) nxt = 6;
             else if (m_ped) begin nxt = 5; m_ped = 1'b0; end
             else if (mode == 1) nxt = 7;
             else nxt = m_next ? 3 : 0;
           end
        5: if (mode == 3) nxt = 6;
           else if (done) nxt = m_next ? 3 : 0;
        6: if (mode != 3) begin nxt = 2; m_next = 1'b0; end
        7: if (mode == 3) nxt = 6;
           else if (mode != 1) begin nxt = 2; m_next = 1'b0; end
        default: nxt = 2;
      endcase
      if (nxt != m_state) begin
        m_state   = nxt;
        m_elapsed = 0;
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end
  end

  // Every cycle: compare all outputs with the model and forbid conflicting greens.
  always @(negedge clk) begin : compare
    int exp_ns;
    int exp_ew;
    int exp_walk;
    int flash;
    if (m_valid) begin
      exp_ns = 0; exp_ew = 0; exp_walk = 0;
      case (m_state)
        0: exp_ns = 2;
        1: exp_ns = 1;
        3: exp_ew = 2;
        4: exp_ew = 1;
        5: exp_walk = 1;
        7: begin
             flash  = (m_elapsed / FLASH_HALF) % 2;
             exp_ns = (flash == 1) ? 3 : 1;
             exp_ew = (flash == 1) ? 3 : 0;
           end
        default: ;
      endcase
      checkOutput("model_phase", int'(phase), m_state);
      checkOutput("model_ns", int'(ns_light), exp_ns);
      checkOutput("model_ew", int'(ew_light), exp_ew);
      checkOutput("model_walk", int'(walk), exp_walk);
      checkOutput("no_conflict",
                  int'((ns_light == 2'b10 && ew_light != 2'b00) ||
                       (ew_light == 2'b10 && ns_light != 2'b00)), 0);
    end
  end

  // Drive inputs for n cycles; returns just after a falling edge.
  task automatic applyStimulus(input logic [1:0] mode, input logic rst_val, input int n);
    for (int i = 0; i < n; i++) begin
      traffic_mode = mode;
      rst_n        = rst_val;
      @(negedge clk);
    end
  endtask

  task automatic wait_for_phase(input logic [1:0] mode, input int target, input int limit);
    int n;
    n = 0;
    while (int'(phase) != target && n < limit) begin
      applyStimulus(mode, 1'b1, 1);
      n++;
    end
    checkOutput("wait_phase", int'(phase), target);
  endtask

  initial begin
    int r;
    int len;
    @(negedge clk);

    // Reset values
    applyStimulus(2'b00, 1'b0, 2);
    checkOutput("rst_phase", int'(phase), 2);
    checkOutput("rst_ns", int'(ns_light), 0);
    checkOutput("rst_ew", int'(ew_light), 0);
    checkOutput("rst_walk", int'(walk), 0);

    // Day cycle: CLR 2, NS_GRN 8, NS_YEL 3, CLR 2, EW_GRN 8, EW_YEL 3
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("day_clr", int'(phase), 2);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("day_nsg", int'(phase), 0);
    checkOutput("day_nsg_lamp", int'(ns_light), 2);
    applyStimulus(2'b00, 1'b1, 7);  checkOutput("day_nsg_end", int'(phase), 0);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("day_nsy", int'(phase), 1);
    checkOutput("day_nsy_lamp", int'(ns_light), 1);
    applyStimulus(2'b00, 1'b1, 3);  checkOutput("day_clr2", int'(phase), 2);
    applyStimulus(2'b00, 1'b1, 2);  checkOutput("day_ewg", int'(phase), 3);
    checkOutput("day_ewg_lamp", int'(ew_light), 2);
    applyStimulus(2'b00, 1'b1, 12); checkOutput("day_clr3", int'(phase), 2);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("day_period", int'(phase), 0);

    // Pedestrian pulse in NS_GRN cycle 2: green not shortened, PED after CLR
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b10, 1'b1, 1);  checkOutput("ped_green_kept", int'(phase), 0);
    applyStimulus(2'b00, 1'b1, 5);  checkOutput("ped_green_full", int'(phase), 0);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("ped_yel", int'(phase), 1);
    applyStimulus(2'b00, 1'b1, 5);  checkOutput("ped_phase", int'(phase), 5);
    checkOutput("ped_walk", int'(walk), 1);
    applyStimulus(2'b00, 1'b1, 4);  checkOutput("ped_end", int'(phase), 5);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("ped_to_ewg", int'(phase), 3);

    // Emergency at NS_GRN cycle 3
    applyStimulus(2'b00, 1'b1, 13); checkOutput("emg_nsg", int'(phase), 0);
    applyStimulus(2'b00, 1'b1, 2);
    applyStimulus(2'b11, 1'b1, 1);  checkOutput("emg_preempt", int'(phase), 1);
    applyStimulus(2'b11, 1'b1, 2);  checkOutput("emg_yel_full", int'(phase), 1);
    applyStimulus(2'b11, 1'b1, 2);  checkOutput("emg_clr", int'(phase), 2);
    applyStimulus(2'b11, 1'b1, 1);  checkOutput("emg_enter", int'(phase), 6);
    applyStimulus(2'b11, 1'b1, 3);  checkOutput("emg_hold", int'(phase), 6);
    applyStimulus(2'b00, 1'b1, 2);  checkOutput("emg_rel_clr", int'(phase), 2);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("emg_rel_nsg", int'(phase), 0);

    // Emergency during PED drops walk at once
    applyStimulus(2'b10, 1'b1, 1);
    wait_for_phase(2'b00, 5, 40);
    applyStimulus(2'b11, 1'b1, 1);  checkOutput("ped_emg", int'(phase), 6);
    checkOutput("ped_emg_walk", int'(walk), 0);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("ped_emg_rel", int'(phase), 2);

    // Night flashing then return via CLR to NS_GRN
    wait_for_phase(2'b01, 7, 60);
    checkOutput("night_ns0", int'(ns_light), 1);
    checkOutput("night_ew0", int'(ew_light), 0);
    applyStimulus(2'b01, 1'b1, 3);  checkOutput("night_ns_hold", int'(ns_light), 1);
    applyStimulus(2'b01, 1'b1, 1);  checkOutput("night_ns1", int'(ns_light), 3);
    checkOutput("night_ew1", int'(ew_light), 3);
    applyStimulus(2'b01, 1'b1, 4);  checkOutput("night_ns2", int'(ns_light), 1);
    applyStimulus(2'b00, 1'b1, 2);  checkOutput("night_exit", int'(phase), 2);
    applyStimulus(2'b00, 1'b1, 1);  checkOutput("night_nsg", int'(phase), 0);

    // Reset mid EW_GRN with a pedestrian request pending
    wait_for_phase(2'b00, 3, 40);
    applyStimulus(2'b10, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 1);  checkOutput("mid_rst_phase", int'(phase), 2);
    checkOutput("mid_rst_ew", int'(ew_light), 0);
    applyStimulus(2'b00, 1'b1, 2);  checkOutput("mid_rst_nsg", int'(phase), 0);

    // Randomized mode sequences checked by the model every cycle
    for (int seg = 0; seg < 900; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        applyStimulus(2'b00, 1'b0, 1);
      end else if (r < 55) begin
        len = int'($urandom_range(1, 30));
        applyStimulus(2'b00, 1'b1, len);
      end else if (r < 70) begin
        len = int'($urandom_range(1, 2));
        applyStimulus(2'b10, 1'b1, len);
      end else if (r < 85) begin
        len = int'($urandom_range(1, 12));
        applyStimulus(2'b11, 1'b1, len);
      end else begin
        len = int'($urandom_range(3, 30));
        applyStimulus(2'b01, 1'b1, len);
      end
    end

    applyStimulus(2'b00, 1'b1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
